// File: rtl/riscv_pkg.sv
// Shared types for the EX issue controller: per-stage scoreboard entry,
// the architectural zero register and the issue FSM states.
package riscv_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
    } slot_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } issue_state_e;

    // True when a read of rs (if used) must wait for the in-flight entry s.
    // x0 is hardwired, so it never creates a dependency.
    function automatic logic src_hazard(input slot_t s, input logic [4:0] rs, input logic used);
        return used && (rs != REG_ZERO) && s.valid && s.we && (s.rd == rs);
    endfunction

endpackage

// File: rtl/riscv_raw_check.sv
// Read-after-write hazard detection over the in-flight scoreboard. Only
// slots younger than FWD_SLOT can stall; from FWD_SLOT onward the result is
// available on the forwarding network.
module riscv_raw_check
    import riscv_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int FWD_SLOT = 5
) (
    input  slot_t [DEPTH-1:0] slots,
    input  logic  [4:0]       rs1_addr,
    input  logic              rs1_used,
    input  logic  [4:0]       rs2_addr,
    input  logic              rs2_used,
    output logic              hazard
);

    localparam int LIMIT = (FWD_SLOT < DEPTH) ? FWD_SLOT : DEPTH;

    // Scan the non-forwardable window for a producer of either source.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            if (src_hazard(slots[k], rs1_addr, rs1_used) ||
                src_hazard(slots[k], rs2_addr, rs2_used)) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_ex_issue_ctrl.sv
// Issue/hazard controller between decode and EX1. Tracks every in-flight
// instruction in a shift-register scoreboard, stalls on unforwardable RAW
// hazards, drains the pipe around serializing instructions and applies
// flush masks to the per-stage valid bits.
module riscv_ex_issue_ctrl
    import riscv_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int FWD_SLOT = 5,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic             id_rs1_used,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_rd_we,
    input  logic             id_serialize,
    output logic             issue_ready,
    input  logic             flush,
    input  logic [DEPTH-1:0] flush_mask,
    output logic [DEPTH-1:0] slot_valid,
    output logic             pipe_empty,
    output logic [CNT_W-1:0] stall_count
);

    slot_t [DEPTH-1:0] slots;
    issue_state_e      state;
    logic              hazard;
    logic              issue_fire;

    riscv_raw_check #(
        .DEPTH    (DEPTH),
        .FWD_SLOT (FWD_SLOT)
    ) u_raw_check (
        .slots    (slots),
        .rs1_addr (id_rs1_addr),
        .rs1_used (id_rs1_used),
        .rs2_addr (id_rs2_addr),
        .rs2_used (id_rs2_used),
        .hazard   (hazard)
    );

    // Expose the registered valid bit of every slot as the stage kill mask.
    always_comb begin
        slot_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_valid[k] = slots[k].valid;
        end
    end

    assign pipe_empty = ~|slot_valid;

    // Accept from decode only in RUN, with no hazard, no flush, and an empty
    // pipe for serializing instructions.
    always_comb begin
        issue_ready = 1'b0;
        if (state == RUN) begin
            issue_ready = id_valid & ~hazard & ~flush & (~id_serialize | pipe_empty);
        end
    end

    assign issue_fire = id_valid & issue_ready;

    // Advance the scoreboard one stage per cycle; flushed entries move on as bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                slots[k] <= '{valid: slots[k-1].valid & ~(flush & flush_mask[k-1]),
                              rd:    slots[k-1].rd,
                              we:    slots[k-1].we};
            end
            if (issue_fire) begin
                slots[0] <= '{valid: 1'b1,
                              rd:    id_rd_addr,
                              we:    id_rd_we & (id_rd_addr != REG_ZERO)};
            end else begin
                slots[0] <= '0;
            end
        end
    end

    // Serialization FSM: enter DRAIN around a serializing instruction and
    // return to RUN once the registered pipe view is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (id_valid && id_serialize && (!pipe_empty || issue_fire)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Count cycles where decode was held back; hold at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (id_valid && !issue_ready && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_ex_issue_ctrl.sv
// Directed bench for the EX issue controller: dependency stalls, x0,
// serialization drain, flush masks and asynchronous reset.
module tb_riscv_ex_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic        id_rs1_used;
    logic [4:0]  id_rs2_addr;
    logic        id_rs2_used;
    logic [4:0]  id_rd_addr;
    logic        id_rd_we;
    logic        id_serialize;
    logic        issue_ready;
    logic        flush;
    logic [7:0]  flush_mask;
    logic [7:0]  slot_valid;
    logic        pipe_empty;
    logic [31:0] stall_count;

    int checks   = 0;
    int failures = 0;

    riscv_ex_issue_ctrl #(
        .DEPTH    (8),
        .FWD_SLOT (5),
        .CNT_W    (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs2_used  (id_rs2_used),
        .id_rd_addr   (id_rd_addr),
        .id_rd_we     (id_rd_we),
        .id_serialize (id_serialize),
        .issue_ready  (issue_ready),
        .flush        (flush),
        .flush_mask   (flush_mask),
        .slot_valid   (slot_valid),
        .pipe_empty   (pipe_empty),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic we, input logic ser, input logic fl,
                                 input logic [7:0] mask);
        id_valid     = v;
        id_rs1_addr  = rs1;
        id_rs1_used  = u1;
        id_rs2_addr  = rs2;
        id_rs2_used  = u2;
        id_rd_addr   = rd;
        id_rd_we     = we;
        id_serialize = ser;
        flush        = fl;
        flush_mask   = mask;
    endtask

    task automatic issueAlu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        applyStimulus(1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 12 && !pipe_empty; i++) tick();
        #2;
        checkOutput("drain_empty", {31'd0, pipe_empty}, 32'd1);
        tick();
    endtask

    initial begin
        $display("[TB] start");
        idle();
        rst_n = 1'b0;
        #2;
        checkOutput("rst_slot_valid", {24'd0, slot_valid}, 32'h00);
        checkOutput("rst_pipe_empty", {31'd0, pipe_empty}, 32'd1);
        checkOutput("rst_issue_ready", {31'd0, issue_ready}, 32'd0);
        checkOutput("rst_stall_count", stall_count, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back dependency: five stall cycles, then forwarded
        issueAlu(5'd5, 5'd1, 5'd2);
        #2 checkOutput("a_prod_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        checkOutput("a_slot0", {24'd0, slot_valid}, 32'h01);
        issueAlu(5'd6, 5'd5, 5'd7);
        for (int i = 0; i < 5; i++) begin
            #2 checkOutput("a_raw_stall", {31'd0, issue_ready}, 32'd0);
            tick();
        end
        #2 checkOutput("a_fwd_ready", {31'd0, issue_ready}, 32'd1);
        checkOutput("a_stall_count", stall_count, 32'd5);
        tick();
        idle();
        #2 checkOutput("a_slots", {24'd0, slot_valid}, 32'h41);
        drain();

        // x0 destination followed by x0 sources: no stall
        issueAlu(5'd0, 5'd1, 5'd2);
        #2 checkOutput("b_x0_write", {31'd0, issue_ready}, 32'd1);
        tick();
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 8'h00);
        #2 checkOutput("b_x0_use", {31'd0, issue_ready}, 32'd1);
        tick();
        idle();
        #2 checkOutput("b_slots", {24'd0, slot_valid}, 32'h03);
        drain();

        // Unused rs1 never hazards; rs2 hazards until producer reaches slot 5
        issueAlu(5'd7, 5'd1, 5'd2);
        #2 checkOutput("r_prod_ready", {31'd0, issue_ready}, 32'd1);
        tick();
        applyStimulus(1'b1, 5'd7, 1'b0, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 8'h00);
        #2 checkOutput("r_rs1_unused", {31'd0, issue_ready}, 32'd1);
        tick();
        applyStimulus(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            #2 checkOutput("r_rs2_stall", {31'd0, issue_ready}, 32'd0);
            tick();
        end
        #2 checkOutput("r_rs2_fwd", {31'd0, issue_ready}, 32'd1);
        checkOutput("r_stall_count", stall_count, 32'd9);
        tick();
        drain();

        // Serialize with three in flight, then a younger waits for it to retire
        issueAlu(5'd10, 5'd1, 5'd2); tick();
        issueAlu(5'd11, 5'd1, 5'd2); tick();
        issueAlu(5'd12, 5'd1, 5'd2); tick();
        checkOutput("c_three_valid", {24'd0, slot_valid}, 32'h07);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            #2 checkOutput("c_ser_wait", {31'd0, issue_ready}, 32'd0);
            if (i == 0) checkOutput("c_not_empty", {31'd0, pipe_empty}, 32'd0);
            if (i == 8) checkOutput("c_now_empty", {31'd0, pipe_empty}, 32'd1);
            tick();
        end
        #2 checkOutput("c_ser_issue", {31'd0, issue_ready}, 32'd1);
        checkOutput("c_stall_count1", stall_count, 32'd18);
        tick();
        issueAlu(5'd13, 5'd1, 5'd2);
        for (int i = 0; i < 9; i++) begin
            #2 checkOutput("c_young_wait", {31'd0, issue_ready}, 32'd0);
            tick();
        end
        #2 checkOutput("c_young_issue", {31'd0, issue_ready}, 32'd1);
        checkOutput("c_stall_count2", stall_count, 32'd27);
        tick();
        drain();

        // Flush slots 0 and 1 with slots 0..2 valid; issue attempt rejected
        issueAlu(5'd14, 5'd1, 5'd2); tick();
        issueAlu(5'd15, 5'd1, 5'd2); tick();
        issueAlu(5'd16, 5'd1, 5'd2); tick();
        applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd17, 1'b1, 1'b0, 1'b1, 8'h03);
        #2 checkOutput("d_flush_reject", {31'd0, issue_ready}, 32'd0);
        tick();
        idle();
        #2 checkOutput("d_survivor", {24'd0, slot_valid}, 32'h08);
        checkOutput("d_stall_count", stall_count, 32'd28);
        drain();

        // Producer in slot 1 flushed: dependent issues the next cycle
        issueAlu(5'd20, 5'd1, 5'd2); tick();
        issueAlu(5'd21, 5'd1, 5'd2); tick();
        applyStimulus(1'b1, 5'd20, 1'b1, 5'd2, 1'b1, 5'd22, 1'b1, 1'b0, 1'b1, 8'h02);
        #2 checkOutput("e_flush_cycle", {31'd0, issue_ready}, 32'd0);
        tick();
        applyStimulus(1'b1, 5'd20, 1'b1, 5'd2, 1'b1, 5'd22, 1'b1, 1'b0, 1'b0, 8'h00);
        #2 checkOutput("e_slots", {24'd0, slot_valid}, 32'h02);
        checkOutput("e_flushed_src", {31'd0, issue_ready}, 32'd1);
        tick();
        idle();
        #2 checkOutput("e_stall_count", stall_count, 32'd29);
        drain();

        // Async reset while draining with four valid slots
        issueAlu(5'd22, 5'd1, 5'd2); tick();
        issueAlu(5'd23, 5'd1, 5'd2); tick();
        issueAlu(5'd24, 5'd1, 5'd2); tick();
        issueAlu(5'd25, 5'd1, 5'd2); tick();
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00);
        #2 checkOutput("f_ser_block", {31'd0, issue_ready}, 32'd0);
        tick();
        idle();
        #2 checkOutput("f_four_valid", {24'd0, slot_valid}, 32'h1E);
        checkOutput("f_stall_before", stall_count, 32'd30);
        rst_n = 1'b0;
        #1;
        checkOutput("f_rst_slots", {24'd0, slot_valid}, 32'h00);
        checkOutput("f_rst_empty", {31'd0, pipe_empty}, 32'd1);
        checkOutput("f_rst_count", stall_count, 32'd0);
        checkOutput("f_rst_ready", {31'd0, issue_ready}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        issueAlu(5'd26, 5'd1, 5'd2);
        #2 checkOutput("f_post_reset", {31'd0, issue_ready}, 32'd1);
        tick();
        idle();
        #2 checkOutput("f_post_slots", {24'd0, slot_valid}, 32'h01);
        checkOutput("f_post_count", stall_count, 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
